// File: rtl/prover_compute_h_pkg.sv
// Shared types for the compute_h collector blocks: collector state enum and field element type.
// The field width comes from the field arithmetic define `F_NBITS (61-bit Mersenne field if not set).
`ifndef F_NBITS
`define F_NBITS 61
`endif

package prover_compute_h_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } parcollect_state_t;

  typedef logic [`F_NBITS-1:0] felem_t;

endpackage

// File: rtl/prover_compute_h_parcollect.sv
// Collects nOutputs multiplier results into a register array, one slot per accepted val_valid.
// Optional macro PROVER_COMPUTE_H_PARCOLLECT_CLEAR_EN: an accepted en also zeroes every slot.
module prover_compute_h_parcollect
  import prover_compute_h_pkg::*;
#(
  parameter int nOutputs   = 2,
  parameter int nCountBits = $clog2(nOutputs)
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  en,
  input  logic [`F_NBITS-1:0]   val_in,
  input  logic                  val_valid,
  output logic [nCountBits-1:0] count_out,
  output logic [`F_NBITS-1:0]   vals_out [nOutputs],
  output logic                  ready,
  output logic                  ready_pulse
);

  if (nOutputs < 2) begin : g_chk_outputs
    $error("prover_compute_h_parcollect: nOutputs must be at least 2");
  end
  if (nCountBits != $clog2(nOutputs)) begin : g_chk_countbits
    $error("prover_compute_h_parcollect: nCountBits is derived from nOutputs and must not be overridden");
  end

  localparam logic [nCountBits-1:0] LAST = nCountBits'(nOutputs - 1);

  parcollect_state_t     r_state;
  parcollect_state_t     w_next_state;
  logic [nCountBits-1:0] r_count;
  felem_t                r_vals [nOutputs];
  logic                  w_start;
  logic                  w_write;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE:    if (en) w_next_state = ST_COLLECT;
      ST_COLLECT: if (val_valid && (r_count == LAST)) w_next_state = ST_DONE;
      ST_DONE:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ready       = (r_state == ST_IDLE);
    ready_pulse = (r_state == ST_DONE);
    w_start     = (r_state == ST_IDLE) && en;
    w_write     = (r_state == ST_COLLECT) && val_valid;
  end

  // Slot index wraps to 0 on the final write so it never exceeds nOutputs-1.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_count <= '0;
    end else if (w_start) begin
      r_count <= '0;
    end else if (w_write) begin
      r_count <= (r_count == LAST) ? '0 : r_count + nCountBits'(1);
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < nOutputs; i++) r_vals[i] <= '0;
    end else begin
`ifdef PROVER_COMPUTE_H_PARCOLLECT_CLEAR_EN
      if (w_start) begin
        for (int i = 0; i < nOutputs; i++) r_vals[i] <= '0;
      end
`endif
      for (int i = 0; i < nOutputs; i++) begin
        if (w_write && (r_count == nCountBits'(i))) r_vals[i] <= val_in;
      end
    end
  end

  assign count_out = r_count;
  assign vals_out  = r_vals;

endmodule

// File: doc/prover_compute_h_parcollect.md
PROVER_COMPUTE_H_PARCOLLECT -- requirements
Module: prover_compute_h_parcollect

Interface
REQ-001 Parameter nOutputs SHALL default to 2 and set the number of collected field elements, with minimum 2.
REQ-002 Parameter nCountBits SHALL default to $clog2(nOutputs) and must not be overridden.
REQ-003 Port clk SHALL be an input, 1 bit wide, and is the sole clock, rising edge.
REQ-004 Port rstb SHALL be an input, 1 bit wide, and is an asynchronous active-low reset.
REQ-005 Port en SHALL be an input, 1 bit wide, and starts a collection pass.
REQ-006 Port val_in SHALL be an input, `F_NBITS wide, and carries the multiplier result.
REQ-007 Port val_valid SHALL be an input, 1 bit wide, and qualifies val_in for one cycle.
REQ-008 Port count_out SHALL be an output, nCountBits wide, and gives the slot index of the next write, which drives the count_in of the upstream mux.
REQ-009 Port vals_out SHALL be an output array of nOutputs elements, each `F_NBITS wide, holding the collected values.
REQ-010 Port ready SHALL be an output, 1 bit wide, and is high while the block is idle.
REQ-011 Port ready_pulse SHALL be an output, 1 bit wide, and is a 1-cycle strobe when all slots are filled.

Function
REQ-012 The block SHALL implement exactly three states: ST_IDLE, ST_COLLECT and ST_DONE.
REQ-013 In ST_IDLE, en=1 SHALL clear count_out to 0 and move the block to ST_COLLECT on the next edge.
REQ-014 In ST_COLLECT, val_valid=1 SHALL write val_in into vals_out[count_out] and increment count_out.
REQ-015 In ST_COLLECT, a write with count_out==nOutputs-1 SHALL move the block to ST_DONE and reset count_out to 0, with no wrap past nOutputs-1.
REQ-016 ST_DONE SHALL last exactly 1 cycle, assert ready_pulse=1, then return to ST_IDLE.
REQ-017 Output ready SHALL equal (state==ST_IDLE), and SHALL rise in the cycle after ready_pulse.
REQ-018 Latency SHALL be 1 cycle from the last accepted val_valid to ready_pulse, so a pass totals nOutputs+1 cycles minimum after en.
REQ-019 Outputs vals_out SHALL hold their values unchanged except during accepted writes, and SHALL remain stable through ST_DONE and ST_IDLE.
REQ-020 val_valid SHALL be ignored in ST_IDLE and ST_DONE.
REQ-021 en SHALL be ignored outside ST_IDLE, including when en arrives together with the final write.
REQ-022 en and val_valid asserted together in ST_IDLE SHALL start the pass only, with no write.
REQ-023 val_valid held low in ST_COLLECT SHALL stall the block without limit, with no timeout.
REQ-024 Writes SHALL be plain register copies with no arithmetic, each slot exactly `F_NBITS wide.

Reset
REQ-025 rstb=0 SHALL force, asynchronously and at any time including mid-pass, state=ST_IDLE, count_out=0, ready=1, ready_pulse=0 and every vals_out element =0.
REQ-026 A partial pass interrupted by reset SHALL be discarded, with no ready_pulse.
REQ-027 Release of rstb SHALL be followed by waiting for en.

Configuration
REQ-028 With macro PROVER_COMPUTE_H_PARCOLLECT_CLEAR_EN defined, an accepted en SHALL also zero all vals_out on the same edge as the start.
REQ-029 With the macro undefined, vals_out SHALL retain the previous pass's values until overwritten slot by slot.

Structure
REQ-030 The state enum and the typedef for an F_NBITS element SHALL reside in shared package prover_compute_h_pkg, and the field width SHALL come from the existing field arithmetic defines.
REQ-031 The block SHALL have no sub-module, being a single FSM with a counter and a register array.
REQ-032 Parameter sanity checks SHALL be generate-time errors for nOutputs<2 and for an overridden nCountBits.

Verification
REQ-033 The bench SHALL check that with nOutputs=4, en followed by 4 consecutive valid inputs 0x11, 0x22, 0x33, 0x44 gives vals_out={0x44,0x33,0x22,0x11}, with ready_pulse 1 cycle after the 4th input and ready high on the next cycle.
REQ-034 The bench SHALL check that gaps of 3 idle cycles between valid inputs give a count_out sequence of 0,1,2,3 that holds during the gaps, with ready_pulse arriving only after the 4th input.
REQ-035 The bench SHALL check that val_valid in ST_IDLE, and en in ST_COLLECT, leave vals_out and count_out unchanged.
REQ-036 The bench SHALL check that rstb pulsed low after 2 of 4 writes zeroes vals_out, returns count_out=0 and ready=1, and produces no ready_pulse.
REQ-037 The bench SHALL check that after a second pass started with only 1 write, vals_out[3:1] holds the first-pass values when PROVER_COMPUTE_H_PARCOLLECT_CLEAR_EN is undefined and 0 when it is defined.
REQ-038 The bench SHALL check that with nOutputs=3 (non-power-of-2), count_out never reaches 3 and ready_pulse occurs after 3 writes.
